weight_pattern_gen: RTL and testbench

Sequential inverse of the 4-bit ones-count lookup. Given a weight k, the block enumerates every WIDTH-bit word whose popcount equals k, in ascending numeric order, one word per accepted handshake. It sits beside the popcount ROM in the lab datapath as its stimulus/decoder counterpart: the ROM maps word→count, this block maps count→all words.

---
 rtl/weight_pattern_gen.sv | 119 +++++++++++
 tb/tb_weight_pattern_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: enumerates every WIDTH-bit word with popcount k in
// ascending order, one word per valid/ready transfer.
module weight_pattern_gen #(
  parameter int WIDTH = 4,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KW-1:0]    weight,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] index,
  output logic             last,
  output logic             busy,
  output logic             err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] pattern_next;
  logic             accept;
  logic             weight_ok;

  // k ones packed into the LSBs: the first word of the sequence
  function automatic logic [WIDTH-1:0] low_ones(input logic [KW-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      m[i] = (i < 32'(k));
    return m;
  endfunction

  // k ones packed into the MSBs: the final word of the sequence
  function automatic logic [WIDTH-1:0] top_ones(input logic [KW-1:0] k);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      m[i] = ((i + 32'(k)) >= 32'(WIDTH));
    return m;
  endfunction

  assign weight_ok = (weight <= WIDTH_K);
  assign accept    = (state == IDLE) && start && weight_ok;

  // Gosper successor; the divide by the lowest set bit becomes a right
  // shift by its trailing-zero count.
  always_comb begin
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    int unsigned      tz;
    logic             found;
    c     = pattern & (~pattern + WIDTH'(1));
    r     = pattern + c;
    d     = pattern ^ r;
    tz    = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && pattern[i]) begin
        tz    = i;
        found = 1'b1;
      end
    end
    pattern_next = r | (d >> (tz + 2));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && weight_ok) state_next = RUN;
      RUN:  if (out_ready && last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only
  always_comb begin
    out_valid = (state == RUN);
    busy      = (state != IDLE);
  end

  // Datapath: weight latch, current word, index, last flag, error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_reg   <= '0;
      pattern <= '0;
      index   <= '0;
      last    <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !weight_ok;
      if (accept) begin
        k_reg   <= weight;
        pattern <= low_ones(weight);
        index   <= '0;
        last    <= (low_ones(weight) == top_ones(weight));
      end else if ((state == RUN) && out_ready && !last) begin
        pattern <= pattern_next;
        index   <= index + WIDTH'(1);
        last    <= (pattern_next == top_ones(k_reg));
      end
    end
  end

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Scoreboard bench for weight_pattern_gen: a brute-force model enumerates
// words by popcount; a monitor pops and compares on every transfer.
module tb_weight_pattern_gen;

  localparam int WIDTH = 4;
  localparam int KW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [KW-1:0]    weight;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] index;
  logic             last;
  logic             busy;
  logic             err;

  weight_pattern_gen #(.WIDTH(WIDTH), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight(weight),
    .out_ready(out_ready), .out_valid(out_valid), .pattern(pattern),
    .index(index), .last(last), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] idx;
    logic             lst;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   xfers  = 0;
  bit   final_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan all words ascending, keep those with k ones
  task automatic expect_run(input int k);
    exp_t e;
    int   n;
    logic [WIDTH-1:0] w;
    if (k > WIDTH) return;
    n = 0;
    for (int v = 0; v < (1 << WIDTH); v++) begin
      w = v[WIDTH-1:0];
      if ($countones(w) == k) begin
        e.pat = w;
        e.idx = n[WIDTH-1:0];
        e.lst = 1'b0;
        sbq.push_back(e);
        n++;
      end
    end
    e = sbq[sbq.size()-1];
    e.lst = 1'b1;
    sbq[sbq.size()-1] = e;
  endtask

  // Monitor: sample away from the active edge; a transfer happens at the
  // following rising edge when valid & ready are seen here.
  logic             held;
  logic [WIDTH-1:0] held_p, held_i;
  logic             held_l;
  initial held = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && held && out_valid) begin
      check("stall_pattern", int'(pattern), int'(held_p));
      check("stall_index",   int'(index),   int'(held_i));
      check("stall_last",    int'(last),    int'(held_l));
    end
    held   = rst_n && out_valid && !out_ready;
    held_p = pattern;
    held_i = index;
    held_l = last;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pattern %0d expected none", pattern);
      end else begin
        e = sbq.pop_front();
        check("pattern", int'(pattern), int'(e.pat));
        check("index",   int'(index),   int'(e.idx));
        check("last",    int'(last),    int'(e.lst));
        if (e.lst) final_seen = 1;
      end
      xfers++;
    end
  end

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_seq(input int k, input int mode, input int restart_at);
    int cyc;
    @(posedge clk); #1;
    start  = 1'b1;
    weight = KW'(k);
    out_ready = ready_for(mode, 0);
    expect_run(k);
    final_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
    if (k > WIDTH) begin
      check("err_pulse",      int'(err),       1);
      check("err_busy",       int'(busy),      0);
      check("err_valid",      int'(out_valid), 0);
      @(posedge clk); #1;
      check("err_deassert",   int'(err),       0);
      check("err_busy2",      int'(busy),      0);
      return;
    end
    check("no_err",         int'(err),       0);
    check("first_latency",  int'(out_valid), 1);
    cyc = 0;
    forever begin
      out_ready = ready_for(mode, cyc);
      if (cyc == restart_at) begin
        start  = 1'b1;
        weight = KW'(3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (final_seen) begin
        check("done_busy",   int'(busy),       0);
        check("done_valid",  int'(out_valid),  0);
        check("done_err",    int'(err),        0);
        check("done_queue",  sbq.size(),       0);
        break;
      end
      if (cyc > 500) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d pending expected 0", sbq.size());
        sbq.delete();
        break;
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},   int'(out_valid), 0);
    check({tag, "_busy"},    int'(busy),      0);
    check({tag, "_pattern"}, int'(pattern),   0);
    check({tag, "_index"},   int'(index),     0);
    check({tag, "_last"},    int'(last),      0);
    check({tag, "_err"},     int'(err),       0);
  endtask

  task automatic reset_mid_run();
    int base;
    int cyc;
    @(posedge clk); #1;
    start = 1'b1; weight = KW'(2); out_ready = 1'b1;
    expect_run(2);
    base = xfers;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (xfers < base + 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midrun_reset");
    rst_n = 1'b1;
    out_ready = 1'b1;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    check("after_reset_idle", int'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; weight = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    run_seq(2, 0, -1);
    run_seq(2, 1, -1);
    run_seq(0, 0, -1);
    run_seq(WIDTH, 0, -1);
    run_seq(WIDTH + 1, 0, -1);
    run_seq(1, 0, 2);
    reset_mid_run();
    run_seq(3, 0, -1);
    for (int n = 0; n < 25; n++)
      run_seq(int'($urandom_range(0, WIDTH + 1)), 2,
              int'($urandom_range(0, 3)));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
